// File: rtl/cmos_capture_8to16.sv
//==============================================================================
// Module   : cmos_capture_8to16
// Brief    : DVP 8-bit camera capture on cmos_pclk. Packs byte pairs into
//            RGB565 words, skips start-up frames, flags malformed lines/frames.
//            Optional frame counter output enabled by macro CMOS_FRAME_CNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmos_capture_8to16 #(
    parameter int IMG_COL     = 512,
    parameter int IMG_ROW     = 8,
    parameter int SKIP_FRAMES = 10,
    parameter int HI_FIRST    = 1
) (
    input  logic        cmos_pclk,
    input  logic        cmos_rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic [15:0] data_16b,
    output logic        data_16b_en,
    output logic        cmos_data_valid,
    output logic        line_err,
    output logic        frame_err
`ifdef CMOS_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int c_LINE_BYTES = 2 * IMG_COL;
    localparam int c_BC_W       = $clog2(c_LINE_BYTES + 2);
    localparam int c_RC_W       = $clog2(IMG_ROW + 1);
    localparam int c_SK_W       = $clog2(SKIP_FRAMES + 2);

    localparam logic [c_BC_W-1:0] c_BC_LINE = c_BC_W'(c_LINE_BYTES);
    localparam logic [c_BC_W-1:0] c_BC_MAX  = c_BC_W'(c_LINE_BYTES + 1);
    localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(IMG_ROW);
    localparam logic [c_SK_W-1:0] c_SKIP    = c_SK_W'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FRAME   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_vs_d;
    logic                r_vs_dd;
    logic                r_hs_d;
    logic                r_hs_dd;
    logic [7:0]          r_dat_d;
    logic [c_SK_W-1:0]   r_skip_cnt;
    logic [c_RC_W-1:0]   r_row_cnt;
    logic [c_BC_W-1:0]   r_byte_cnt;
    logic                r_byte_phase;
    logic [7:0]          r_first_byte;

    logic                w_hs_act;
    logic                w_vs_rise;
    logic                w_vs_fall;
    logic                w_hs_fall;
    logic [c_RC_W-1:0]   w_row_next;
    logic                w_line_bad;
    logic                w_frame_done;
    logic [15:0]         w_word;

    // href is masked while vsync is high so overlapping pulses count as vsync
    assign w_hs_act     = r_hs_d & ~r_vs_d;
    assign w_vs_rise    = r_vs_d & ~r_vs_dd;
    assign w_vs_fall    = ~r_vs_d & r_vs_dd;
    assign w_hs_fall    = r_hs_dd & ~w_hs_act;
    assign w_row_next   = r_row_cnt + c_RC_W'(1);
    assign w_line_bad   = (r_byte_cnt != c_BC_LINE) || r_byte_phase;
    assign w_frame_done = w_hs_fall && (w_row_next == c_RC_LAST);

    generate
        if (HI_FIRST != 0) begin : g_hi_first
            assign w_word = {r_first_byte, r_dat_d};
        end else begin : g_lo_first
            assign w_word = {r_dat_d, r_first_byte};
        end
    endgenerate

    always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
        if (cmos_rst) begin
            r_vs_d  <= 1'b0;
            r_vs_dd <= 1'b0;
            r_hs_d  <= 1'b0;
            r_hs_dd <= 1'b0;
            r_dat_d <= '0;
        end else begin
            r_vs_d  <= cmos_vsync;
            r_vs_dd <= r_vs_d;
            r_hs_d  <= cmos_href;
            r_hs_dd <= w_hs_act;
            r_dat_d <= cmos_data;
        end
    end

    always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
        if (cmos_rst) begin
            r_state         <= ST_SKIP;
            r_skip_cnt      <= '0;
            r_row_cnt       <= '0;
            r_byte_cnt      <= '0;
            r_byte_phase    <= 1'b0;
            r_first_byte    <= '0;
            data_16b        <= '0;
            data_16b_en     <= 1'b0;
            cmos_data_valid <= 1'b0;
            line_err        <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            data_16b_en <= 1'b0;
            frame_err   <= 1'b0;
            case (r_state)
                ST_SKIP: begin
                    if (r_skip_cnt == c_SKIP) begin
                        r_state <= ST_WAIT_VS;
                    end else if (w_vs_fall) begin
                        r_skip_cnt <= r_skip_cnt + c_SK_W'(1);
                    end
                end
                ST_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_row_cnt       <= '0;
                        r_byte_cnt      <= '0;
                        r_byte_phase    <= 1'b0;
                        line_err        <= 1'b0;
                        cmos_data_valid <= 1'b1;
                        r_state         <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (w_hs_fall) begin
                        // an odd trailing byte is simply discarded with the phase
                        if (w_line_bad) begin
                            line_err <= 1'b1;
                        end
                        r_row_cnt    <= w_row_next;
                        r_byte_cnt   <= '0;
                        r_byte_phase <= 1'b0;
                        if (w_row_next == c_RC_LAST) begin
                            cmos_data_valid <= 1'b0;
                            r_state         <= ST_WAIT_VS;
                        end
                    end else if (w_hs_act) begin
                        r_byte_phase <= ~r_byte_phase;
                        if (r_byte_cnt != c_BC_MAX) begin
                            r_byte_cnt <= r_byte_cnt + c_BC_W'(1);
                        end
                        if (!r_byte_phase) begin
                            r_first_byte <= r_dat_d;
                        end else begin
                            data_16b    <= w_word;
                            data_16b_en <= 1'b1;
                        end
                    end
                    if (w_vs_rise && !w_frame_done) begin
                        frame_err       <= 1'b1;
                        cmos_data_valid <= 1'b0;
                        r_state         <= ST_WAIT_VS;
                    end
                end
                default: r_state <= ST_SKIP;
            endcase
        end
    end

`ifdef CMOS_FRAME_CNT_EN
    // counts on the same edge that closes a clean, complete window
    always_ff @(posedge cmos_pclk or posedge cmos_rst) begin
        if (cmos_rst) begin
            frame_cnt <= '0;
        end else if ((r_state == ST_FRAME) && w_frame_done && !line_err && !w_line_bad) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmos_capture_8to16.sv
//==============================================================================
// Module   : tb_cmos_capture_8to16
// Brief    : Self-checking bench for cmos_capture_8to16 (three configurations
//            sharing one DVP bus), frame-shape table plus random pixel bytes.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cmos_capture_8to16;

    localparam int IMG_COL = 4;
    localparam int IMG_ROW = 2;
    localparam int NI      = 3;
    localparam int MAXW    = 32;
    localparam int NVEC    = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    logic [NI-1:0][15:0] d16;
    logic [NI-1:0]       en;
    logic [NI-1:0]       valid;
    logic [NI-1:0]       lerr;
    logic [NI-1:0]       ferr;
`ifdef CMOS_FRAME_CNT_EN
    logic [NI-1:0][15:0] fcnt;
`endif

    cmos_capture_8to16 #(.IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .SKIP_FRAMES(2), .HI_FIRST(1)) u_dut_skip (
        .cmos_pclk(clk), .cmos_rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .data_16b(d16[0]), .data_16b_en(en[0]), .cmos_data_valid(valid[0]),
        .line_err(lerr[0]), .frame_err(ferr[0])
`ifdef CMOS_FRAME_CNT_EN
        , .frame_cnt(fcnt[0])
`endif
    );

    cmos_capture_8to16 #(.IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .SKIP_FRAMES(0), .HI_FIRST(1)) u_dut_hi (
        .cmos_pclk(clk), .cmos_rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .data_16b(d16[1]), .data_16b_en(en[1]), .cmos_data_valid(valid[1]),
        .line_err(lerr[1]), .frame_err(ferr[1])
`ifdef CMOS_FRAME_CNT_EN
        , .frame_cnt(fcnt[1])
`endif
    );

    cmos_capture_8to16 #(.IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW), .SKIP_FRAMES(0), .HI_FIRST(0)) u_dut_lo (
        .cmos_pclk(clk), .cmos_rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
        .data_16b(d16[2]), .data_16b_en(en[2]), .cmos_data_valid(valid[2]),
        .line_err(lerr[2]), .frame_err(ferr[2])
`ifdef CMOS_FRAME_CNT_EN
        , .frame_cnt(fcnt[2])
`endif
    );

    typedef struct {
        int nlines;
        int len0;
        int len1;
        bit fixed;
        int exp_words;
        bit exp_lerr;
        bit exp_ferr;
    } vec_t;

    vec_t       tbl [NVEC];
    int         skip_cfg [NI];
    int         hi_cfg [NI];
    int         good_cnt [NI];
    logic [7:0] pat [16];
    logic [7:0] lb [2][16];
    int         lens [2];
    int         sb_cyc;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         got_n [NI];
    logic [15:0] got_w [NI][MAXW];
    int         rise_n [NI];
    int         ferr_n [NI];
    int         first_en_cyc [NI];
    int         last_en_cyc [NI];
    int         fall_cyc [NI];
    logic [NI-1:0] prev_valid = '0;

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got 0x%0h required 0x%0h (cycle %0d)", name, inst, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (en[i]) begin
                chk("strobe_inside_window", i, int'(valid[i]), 1);
                if (got_n[i] == 0) first_en_cyc[i] = cyc;
                if (got_n[i] < MAXW) got_w[i][got_n[i]] = d16[i];
                got_n[i]++;
                last_en_cyc[i] = cyc;
            end
            if (valid[i] && !prev_valid[i]) rise_n[i]++;
            if (!valid[i] && prev_valid[i]) fall_cyc[i] = cyc;
            if (ferr[i]) ferr_n[i]++;
            prev_valid[i] = valid[i];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < NI; i++) begin
            got_n[i]        = 0;
            rise_n[i]       = 0;
            ferr_n[i]       = 0;
            first_en_cyc[i] = -1;
            last_en_cyc[i]  = -1;
            fall_cyc[i]     = -1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_data"},  i, int'(d16[i]),   0);
            chk({tag, "_en"},    i, int'(en[i]),    0);
            chk({tag, "_valid"}, i, int'(valid[i]), 0);
            chk({tag, "_lerr"},  i, int'(lerr[i]),  0);
            chk({tag, "_ferr"},  i, int'(ferr[i]),  0);
`ifdef CMOS_FRAME_CNT_EN
            chk({tag, "_fcnt"},  i, int'(fcnt[i]),  0);
`endif
        end
    endtask

    // Enters with vsync high; vsync low starts frame idx, lines follow, then vsync rises again.
    task automatic run_frame(input vec_t v, input int idx);
        int          k;
        bit          cap;
        logic [15:0] w;
        clear_mon();
        lens[0] = v.len0;
        lens[1] = v.len1;
        for (int l = 0; l < 2; l++)
            for (int b = 0; b < 16; b++)
                lb[l][b] = v.fixed ? pat[(l * 8 + b) % 16] : 8'($urandom_range(0, 255));
        sb_cyc = -1;
        vsync = 1'b0;
        tick(5);
        for (int l = 0; l < v.nlines; l++) begin
            for (int b = 0; b < lens[l]; b++) begin
                href = 1'b1;
                data = lb[l][b];
                if (l == 0 && b == 1) sb_cyc = cyc;
                tick(1);
            end
            href = 1'b0;
            data = 8'h00;
            tick(4);
        end
        tick(4);
        for (int i = 0; i < NI; i++) begin
            cap = (idx >= skip_cfg[i]);
            chk("valid_rise_count", i, rise_n[i], cap ? 1 : 0);
            chk("word_count", i, got_n[i], cap ? v.exp_words : 0);
            if (cap) begin
                k = 0;
                for (int l = 0; l < v.nlines; l++) begin
                    for (int p = 0; p < lens[l] / 2; p++) begin
                        w = (hi_cfg[i] != 0) ? {lb[l][2*p], lb[l][2*p+1]} : {lb[l][2*p+1], lb[l][2*p]};
                        if (k < got_n[i] && k < MAXW) chk("word_value", i, int'(got_w[i][k]), int'(w));
                        k++;
                    end
                end
                if (v.exp_words > 0) chk("strobe_latency", i, first_en_cyc[i], sb_cyc + 2);
                chk("line_err", i, int'(lerr[i]), int'(v.exp_lerr));
                if (!v.exp_ferr) begin
                    chk("valid_closed", i, int'(valid[i]), 0);
                    chk("valid_fall_after_last", i, fall_cyc[i], last_en_cyc[i] + 1);
                    if (!v.exp_lerr) good_cnt[i]++;
                end else begin
                    chk("valid_open_short_frame", i, int'(valid[i]), 1);
                end
            end else begin
                chk("line_err_skipped", i, int'(lerr[i]), 0);
            end
`ifdef CMOS_FRAME_CNT_EN
            chk("frame_cnt", i, int'(fcnt[i]), good_cnt[i] & 16'hFFFF);
`endif
        end
        vsync = 1'b1;
        tick(5);
        for (int i = 0; i < NI; i++) begin
            cap = (idx >= skip_cfg[i]);
            chk("frame_err_pulses", i, ferr_n[i], (cap && v.exp_ferr) ? 1 : 0);
            chk("valid_low_between", i, int'(valid[i]), 0);
            if (cap) chk("line_err_sticky", i, int'(lerr[i]), int'(v.exp_lerr));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        skip_cfg = '{2, 0, 0};
        hi_cfg   = '{1, 1, 0};
        good_cnt = '{0, 0, 0};
        pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hEE, 8'hFF};
        //          nl len0 len1 fix words lerr ferr
        tbl[0] = '{2, 8, 8, 1'b1, 8, 1'b0, 1'b0};
        tbl[1] = '{2, 8, 8, 1'b0, 8, 1'b0, 1'b0};
        tbl[2] = '{2, 8, 8, 1'b0, 8, 1'b0, 1'b0};
        tbl[3] = '{2, 7, 8, 1'b0, 7, 1'b1, 1'b0};
        tbl[4] = '{2, 8, 8, 1'b0, 8, 1'b0, 1'b0};
        tbl[5] = '{1, 8, 0, 1'b0, 4, 1'b0, 1'b1};
        tbl[6] = '{2, 8, 8, 1'b0, 8, 1'b0, 1'b0};
        tbl[7] = '{2, 9, 8, 1'b0, 8, 1'b1, 1'b0};
        tbl[8] = '{2, 6, 8, 1'b0, 7, 1'b1, 1'b0};
        tbl[9] = '{2, 8, 8, 1'b0, 8, 1'b0, 1'b0};
        clear_mon();

        rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            for (int i = 0; i < NI; i++) begin
                chk("idle_valid", i, int'(valid[i]), 0);
                chk("idle_data", i, int'(d16[i]), 0);
            end
        end

        vsync = 1'b1;
        tick(4);
        for (int f = 0; f < NVEC; f++) begin
            run_frame(tbl[f], f);
            if (f == 0) begin
                chk("first_word_hi", 1, int'(got_w[1][0]), 16'h1234);
                chk("last_word_hi", 1, int'(got_w[1][7]), 16'hEEFF);
                chk("first_word_lo", 2, int'(got_w[2][0]), 16'h3412);
            end
        end

        // reset asserted part-way through a line
        vsync = 1'b0;
        tick(5);
        href = 1'b1;
        for (int b = 0; b < 3; b++) begin
            data = 8'($urandom_range(0, 255));
            tick(1);
        end
        chk("valid_before_reset", 1, int'(valid[1]), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midline_reset");
        href = 1'b0;
        vsync = 1'b1;
        tick(2);
        rst = 1'b0;
        good_cnt = '{0, 0, 0};
        tick(4);
        for (int f = 0; f < 4; f++) run_frame(tbl[f], f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
